// File: rtl/eda_regional_max_host.sv
// eda_regional_max_host: loads a raster pixel stream into the regional-max
// core RAM, pulses start, waits for done, then streams the mask row by row.
// Ports: clk/reset_n; s_valid/s_ready/s_pixel pixel input stream;
// wr_addr/pixel_in/write_en core RAM writes; start/done/matrix_output core
// control; m_valid/m_ready/m_row/m_row_idx/m_last result rows;
// busy (not IDLE), timeout_err (sticky, done never came).

package eda_regional_max_host_pkg;
  localparam int CFG_M = 4;
  localparam int CFG_N = 4;
  localparam int CFG_PIXEL_WIDTH = 8;
  localparam int CFG_I_WIDTH = 2;
  localparam int CFG_J_WIDTH = 2;
  localparam int CFG_ADDR_WIDTH = CFG_I_WIDTH + CFG_J_WIDTH;
endpackage

module eda_regional_max_host
  import eda_regional_max_host_pkg::*;
#(
  parameter int M = CFG_M,
  parameter int N = CFG_N,
  parameter int PIXEL_WIDTH = CFG_PIXEL_WIDTH,
  parameter int I_WIDTH = CFG_I_WIDTH,
  parameter int J_WIDTH = CFG_J_WIDTH,
  parameter int ADDR_WIDTH = CFG_ADDR_WIDTH,
  parameter int TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIXEL_WIDTH-1:0] s_pixel,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [PIXEL_WIDTH-1:0] pixel_in,
  output logic                   write_en,
  output logic                   start,
  input  logic                   done,
  input  logic [M*N-1:0]         matrix_output,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [N-1:0]           m_row,
  output logic [I_WIDTH-1:0]     m_row_idx,
  output logic                   m_last,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WGAP,
    START,
    WAIT,
    SEND
  } state_t;

  state_t state;
  state_t nxt;

  // Low only until the first edge after reset release, so that the
  // Moore outputs of IDLE (s_ready) stay at reset values meanwhile.
  logic armed;

  logic [I_WIDTH-1:0] i_cnt;
  logic [J_WIDTH-1:0] j_cnt;
  logic               last_q;
  logic [TW-1:0]      t_cnt;
  logic [M*N-1:0]     res_q;
  logic [I_WIDTH-1:0] r_cnt;

  logic accept;
  logic j_end;
  logic i_end;
  logic tmo_hit;
  logic row_last;

  assign s_ready  = armed && (state == IDLE || state == LOAD);
  assign accept   = s_valid && s_ready;
  assign j_end    = j_cnt == J_WIDTH'(N - 1);
  assign i_end    = i_cnt == I_WIDTH'(M - 1);
  assign tmo_hit  = t_cnt == TW'(TIMEOUT - 1);
  assign row_last = r_cnt == I_WIDTH'(M - 1);

  assign write_en  = state == WGAP;
  assign start     = state == START;
  assign m_valid   = state == SEND;
  assign busy      = state != IDLE;
  assign m_row_idx = r_cnt;
  assign m_last    = m_valid && row_last;
  assign m_row     = res_q[int'(r_cnt) * N +: N];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, LOAD: begin
        if (accept) nxt = WGAP;
      end
      WGAP: begin
        nxt = last_q ? START : LOAD;
      end
      START: begin
        nxt = WAIT;
      end
      WAIT: begin
        if (done) nxt = SEND;
        else if (tmo_hit) nxt = IDLE;
      end
      SEND: begin
        if (m_ready && row_last) nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // Pixel capture and raster counters. The counters wrap back to {0,0}
  // on the last pixel, so every new frame starts at address 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr  <= '0;
      pixel_in <= '0;
      last_q   <= 1'b0;
      i_cnt    <= '0;
      j_cnt    <= '0;
    end else if (accept) begin
      wr_addr  <= {i_cnt, j_cnt};
      pixel_in <= s_pixel;
      last_q   <= i_end && j_end;
      j_cnt    <= j_end ? '0 : j_cnt + 1'b1;
      if (j_end) begin
        i_cnt <= i_end ? '0 : i_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_cnt <= '0;
    end else if (state == START) begin
      t_cnt <= '0;
    end else if (state == WAIT) begin
      t_cnt <= t_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_err <= 1'b0;
    end else if (state == IDLE && accept) begin
      timeout_err <= 1'b0;
    end else if (state == WAIT && !done && tmo_hit) begin
      timeout_err <= 1'b1;
    end
  end

  // Result capture; the core may change matrix_output once done is seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q <= '0;
      r_cnt <= '0;
    end else if (state == WAIT && done) begin
      res_q <= matrix_output;
      r_cnt <= '0;
    end else if (state == SEND && m_ready) begin
      r_cnt <= row_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_eda_regional_max_host.sv
// tb_eda_regional_max_host: table-driven and randomized frames against a
// stream-level model of the host (pixel order, image RAM, result rows).

module tb_eda_regional_max_host;

  localparam int M = 4;
  localparam int N = 4;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_pixel = '0;
  logic [3:0] wr_addr;
  logic [7:0] pixel_in;
  logic       write_en;
  logic       start;
  logic       done = 1'b0;
  logic [15:0] matrix_output = '0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [3:0] m_row;
  logic [1:0] m_row_idx;
  logic       m_last;
  logic       busy;
  logic       timeout_err;

  always #5 clk = ~clk;

  eda_regional_max_host #(
    .M(M),
    .N(N),
    .PIXEL_WIDTH(8),
    .I_WIDTH(2),
    .J_WIDTH(2),
    .ADDR_WIDTH(4),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_pixel(s_pixel),
    .wr_addr(wr_addr),
    .pixel_in(pixel_in),
    .write_en(write_en),
    .start(start),
    .done(done),
    .matrix_output(matrix_output),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_row(m_row),
    .m_row_idx(m_row_idx),
    .m_last(m_last),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [15:0] mat;
    logic [3:0]  rows [4];
    int          vpct;
    int          rpct;
    bit          ramp;
    bit          stall;
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t",
               name, act, req, $time);
    end
  endtask

  function automatic vec_t mkvec(input logic [15:0] mat,
                                 input logic [3:0] r0, input logic [3:0] r1,
                                 input logic [3:0] r2, input logic [3:0] r3,
                                 input int vpct, input int rpct,
                                 input bit ramp, input bit stall);
    vec_t v;
    v.mat = mat;
    v.rows[0] = r0;
    v.rows[1] = r1;
    v.rows[2] = r2;
    v.rows[3] = r3;
    v.vpct = vpct;
    v.rpct = rpct;
    v.ramp = ramp;
    v.stall = stall;
    return v;
  endfunction

  // Reference model state
  logic [7:0]  pix [16];
  logic [7:0]  ram [16];
  logic [7:0]  exp_pix [$];
  logic [3:0]  exp_rows [4];
  logic [15:0] cur_mat = '0;
  logic [3:0]  prev_addr = '0;
  bit mon_en = 0, exp_tmo = 0, core_en = 1, vfull = 0, stall_mode = 0;
  bit in_wait = 0, sending = 0, prev_we = 0, prev_dw = 0;
  bit after_last = 0, frame_done = 0;
  int wr_cnt = 0, start_cnt = 0, cyc = 0, first_we_cyc = 0;
  int since_start = -1, ridx = 0, stall_cnt = 0, stall_left = 0;
  int ready_pct = 100, core_cnt = 0;

  // Monitor: samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      cyc++;
      if (after_last) begin
        chk("idle_after_last", int'({busy, m_valid, s_ready}), 1);
        after_last = 0;
      end
      if (prev_dw) begin
        chk("valid_after_done", int'({m_valid, m_row_idx}), 4);
        prev_dw = 0;
      end
      if (write_en) begin
        chk("we_back_to_back", int'(prev_we), 0);
        if (exp_pix.size() == 0) chk("write_without_hs", int'(write_en), 0);
        else chk("pixel_in", int'(pixel_in), int'(exp_pix.pop_front()));
        chk("wr_addr", int'(wr_addr), wr_cnt);
        if (wr_cnt == 0) begin
          first_we_cyc = cyc;
          chk("tmo_clear_on_first", int'(timeout_err), 0);
        end
        ram[wr_addr] = pixel_in;
        wr_cnt++;
      end
      if (start) begin
        chk("start_after_last_write", int'({prev_we, prev_addr}), 'h1F);
        chk("start_single", int'(in_wait), 0);
        if (vfull) chk("load_cycles", cyc - first_we_cyc, 2 * M * N - 1);
        for (int k = 0; k < 16; k++) chk("ram_image", int'(ram[k]), int'(pix[k]));
        start_cnt++;
        in_wait = 1;
        since_start = 0;
      end else if (since_start >= 0) begin
        since_start++;
      end
      if (exp_tmo && since_start > 0) begin
        if (since_start < TMO + 1) begin
          chk("tmo_waiting", int'({busy, timeout_err}), 2);
        end else begin
          chk("tmo_idle", int'({busy, timeout_err}), 1);
          in_wait = 0;
          since_start = -1;
          frame_done = 1;
        end
      end
      if (m_valid) begin
        chk("m_valid_allowed", int'(in_wait || sending), 1);
        chk("no_valid_on_tmo", int'(exp_tmo), 0);
        if (in_wait) begin
          in_wait = 0;
          sending = 1;
          ridx = 0;
          since_start = -1;
        end
        if (ridx < M) chk("m_row", int'(m_row), int'(exp_rows[ridx]));
        else chk("extra_row", ridx, M - 1);
        chk("m_row_idx", int'(m_row_idx), ridx);
        chk("m_last", int'(m_last), int'(ridx == M - 1));
        if (!m_ready && ridx == 1) stall_cnt++;
        if (m_ready) begin
          if (ridx == M - 1) begin
            sending = 0;
            frame_done = 1;
            after_last = 1;
          end
          ridx++;
        end
      end else begin
        chk("m_last_low", int'(m_last), 0);
        if (sending) chk("valid_dropped", int'(m_valid), 1);
      end
      if (done && in_wait && !exp_tmo) prev_dw = 1;
      if (s_valid && s_ready) exp_pix.push_back(s_pixel);
      prev_we = write_en;
      prev_addr = wr_addr;
    end
  end

  // Model core: done 5 cycles after start, held until the next start;
  // result bus is scrambled once the host has latched it.
  initial forever begin
    @(posedge clk);
    #1;
    if (start) begin
      done = 1'b0;
      core_cnt = 5;
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0 && core_en) done = 1'b1;
    end
    if (m_valid && m_row_idx == 2'd0) matrix_output = ~cur_mat;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (stall_mode && m_valid && m_row_idx == 2'd1 && stall_left > 0) begin
      m_ready = 1'b0;
      stall_left--;
    end else begin
      m_ready = ($urandom_range(99) < ready_pct);
    end
  end

  task automatic send_pixels(input int vpct, input int count);
    int k = 0;
    int guard = 0;
    bit hs;
    s_valid = 1'b0;
    while (k < count && guard < 2000) begin
      if (!s_valid && $urandom_range(99) < vpct) begin
        s_valid = 1'b1;
        s_pixel = pix[k];
      end
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk);
      #1;
      guard++;
      if (hs) begin
        k++;
        s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    if (k < count) chk("send_budget", k, count);
  endtask

  task automatic run_frame(input vec_t v, input bit tmo);
    int sc = start_cnt;
    int guard = 0;
    for (int k = 0; k < 16; k++) pix[k] = v.ramp ? 8'(k) : 8'($urandom);
    for (int r = 0; r < 4; r++) exp_rows[r] = v.rows[r];
    cur_mat = v.mat;
    matrix_output = v.mat;
    core_en = !tmo;
    exp_tmo = tmo;
    ready_pct = v.rpct;
    stall_mode = v.stall;
    stall_left = 3;
    stall_cnt = 0;
    vfull = (v.vpct >= 100);
    wr_cnt = 0;
    frame_done = 0;
    send_pixels(v.vpct, 16);
    while (!frame_done && guard < 600) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("frame_complete", int'(frame_done), 1);
    if (v.stall) chk("stall_cycles", stall_cnt, 3);
    chk("start_pulses", start_cnt - sc, 1);
    chk("hs_queue_empty", exp_pix.size(), 0);
    exp_tmo = 0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  initial begin
    int sc;
    vec_t v;
    vecs[0] = mkvec(16'h8421, 4'h1, 4'h2, 4'h4, 4'h8, 100, 100, 1, 0);
    vecs[1] = mkvec(16'h8421, 4'h1, 4'h2, 4'h4, 4'h8, 100, 100, 0, 1);
    vecs[2] = mkvec(16'hF0A5, 4'h5, 4'hA, 4'h0, 4'hF, 50, 100, 0, 0);
    vecs[3] = mkvec(16'h1234, 4'h4, 4'h3, 4'h2, 4'h1, 50, 60, 0, 0);
    vecs[4] = mkvec(16'hFFFF, 4'hF, 4'hF, 4'hF, 4'hF, 30, 40, 0, 0);
    vecs[5] = mkvec(16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 100, 50, 1, 0);

    #1;
    chk("reset_outputs", int'({s_ready, write_en, start, wr_addr, pixel_in,
        m_valid, m_row, m_row_idx, m_last, busy, timeout_err}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("s_ready_at_release", int'(s_ready), 0);
    @(negedge clk);
    chk("s_ready_after_release", int'(s_ready), 1);
    @(posedge clk);
    #1;
    mon_en = 1;

    for (int i = 0; i < 6; i++) run_frame(vecs[i], 1'b0);

    run_frame(vecs[2], 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("tmo_sticky", int'({busy, timeout_err}), 1);
    run_frame(vecs[0], 1'b0);

    for (int k = 0; k < 16; k++) pix[k] = 8'($urandom);
    sc = start_cnt;
    wr_cnt = 0;
    vfull = 0;
    core_en = 1;
    send_pixels(100, 7);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_mid_outputs", int'({s_ready, write_en, start, wr_addr, pixel_in,
        m_valid, m_row, m_row_idx, m_last, busy, timeout_err}), 0);
    chk("writes_before_reset", wr_cnt, 7);
    exp_pix.delete();
    wr_cnt = 0;
    prev_we = 0;
    prev_dw = 0;
    in_wait = 0;
    sending = 0;
    after_last = 0;
    since_start = -1;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("no_start_after_reset", start_cnt - sc, 0);
    run_frame(vecs[3], 1'b0);

    for (int f = 0; f < 8; f++) begin
      v.mat = 16'($urandom);
      for (int r = 0; r < 4; r++) v.rows[r] = v.mat[r*4 +: 4];
      v.vpct = $urandom_range(20, 100);
      v.rpct = $urandom_range(25, 100);
      v.ramp = 0;
      v.stall = 0;
      run_frame(v, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
